// File: rtl/adder_arbiter_pkg.sv
// Shared types and defaults for the round-robin shared-adder block.
package adder_arbiter_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] gnt_id,
  output logic             gnt_any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = PTR_W'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// N_REQ requesters share one adder: round-robin accept, one-cycle add, hold until consumed.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [WIDTH:0]         rsp_sum,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_ready,
  output logic                   busy
);

  state_e            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  a_sel, b_sel;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_any;
  logic              accept;

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  // Only the granted lane is muxed in, so junk on other lanes never reaches the adder.
  assign a_sel = req_a[int'(gnt_id)*WIDTH +: WIDTH];
  assign b_sel = req_b[int'(gnt_id)*WIDTH +: WIDTH];

  assign accept    = (state == ST_IDLE) && !rst && gnt_any;
  assign req_ready = accept ? gnt : '0;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q    <= a_sel;
            b_q    <= b_sel;
            id_q   <= gnt_id;
            rr_ptr <= (int'(gnt_id) == N_REQ-1) ? '0 : gnt_id + 1'b1;
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          rsp_sum   <= {1'b0, a_q} + {1'b0, b_q};
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the adder (2..8).
REQ-002 Parameter WIDTH, default 3: operand width; sum width is WIDTH+1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req_valid  input  N_REQ  per-requester operand-pair valid.
REQ-006 req_a  input  N_REQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  N_REQ*WIDTH  operand B, same packing as req_a.
REQ-008 req_ready  output  N_REQ  one-hot or zero; bit i means requester i accepted this cycle.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_sum  output  WIDTH+1  unsigned sum a+b, carry in MSB.
REQ-011 rsp_id  output  clog2(N_REQ)  index of requester owning rsp_sum.
REQ-012 rsp_ready  input  1  consumer accepts result.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states IDLE, CALC, HOLD; encoding free.
REQ-015 IDLE: if any req_valid, req_ready SHALL assert for exactly one requester, the first valid at or after rr_ptr in ascending wrap-around order; else req_ready=0.
REQ-016 req_ready SHALL be combinational from req_valid, rr_ptr and state, and zero outside IDLE.
REQ-017 On accept (req_valid[i]&req_ready[i]): register a, b, id=i; rr_ptr <= (i+1) mod N_REQ; state -> CALC.
REQ-018 CALC: register rsp_sum = zero-extended a + zero-extended b, rsp_id = id; state -> HOLD; rsp_valid high from the following cycle.
REQ-019 Latency: rsp_valid SHALL rise exactly 2 cycles after the accept edge.
REQ-020 HOLD: rsp_valid=1; rsp_sum, rsp_id stable until rsp_valid&rsp_ready; on that edge rsp_valid <= 0, state -> IDLE.
REQ-021 No new request SHALL be accepted in the HOLD cycle in which rsp_ready is high; next accept earliest one cycle later (max throughput 1 per 3 cycles).
REQ-022 rsp_ready held low SHALL stall indefinitely with no loss or corruption.
REQ-023 Overflow: 7+7 with WIDTH=3 SHALL give rsp_sum=4'b1110; no truncation, no saturation.
REQ-024 req_valid deasserting in IDLE without accept SHALL have no effect on rr_ptr or state.
REQ-025 req_a/req_b of non-granted requesters SHALL never influence rsp_sum.
REQ-026 rr_ptr wraps from N_REQ-1 to 0.
REQ-027 No X on any output after reset regardless of input X on un-granted lanes.

Reset
REQ-028 rst high: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0, req_ready=0 during the reset cycle.
REQ-029 rst asserted in CALC or HOLD SHALL discard the in-flight operation; no rsp_valid for it after reset releases.
REQ-030 First accept possible in the first cycle after rst deasserts.

Structure
REQ-031 Shared package holds the FSM state typedef/encodings and the default N_REQ/WIDTH constants.
REQ-032 One sub-module, rr_arbiter (N_REQ-wide round-robin grant from request vector and pointer, combinational); adder kept inline in adder_arbiter.

Verification
REQ-033 Single: after reset, req_valid=4'b0001, a0=2, b0=1 -> req_ready=4'b0001 same cycle; rsp_valid 2 cycles later, rsp_sum=3, rsp_id=0.
REQ-034 Round-robin: all four valid continuously, rsp_ready=1, a_i=i, b_i=1 -> grants in order 0,1,2,3,0, sums 1,2,3,4,1, one accept per 3 cycles.
REQ-035 Overflow: a=7, b=7 on requester 2 -> rsp_sum=14, rsp_id=2.
REQ-036 Backpressure: rsp_ready=0 for 10 cycles in HOLD -> rsp_valid, rsp_sum, rsp_id constant, req_ready=0 throughout; release -> one handshake, return to IDLE.
REQ-037 Reset mid-op: assert rst in CALC -> next cycle outputs at reset values, no rsp_valid for discarded op, rr_ptr=0.
REQ-038 Pointer wrap: grant requester 3 alone, then valid on 0 and 3 -> requester 0 granted.
